// File: rtl/uart_tx_if.sv
// AXI-Stream byte channel feeding the UART transmitter.
// The master drives the data and valid lines; the slave returns ready.
interface uart_tx_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;

   modport master (
      output tdata,
      output tvalid,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tvalid,
      output tready
   );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start, data LSB first, optional parity, 1 or 2 stops.
// A one-entry holding register lets frames go out back-to-back.
module uart_tx #(
   parameter int DATA_WIDTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   uart_tx_if.slave    s_axis,
   output logic        o_txd,
   output logic        o_busy,
   input  logic [15:0] i_prescale,
   input  logic        i_parity_en,
   input  logic        i_parity_odd,
   input  logic        i_stop2
);
   localparam int BW = $clog2(DATA_WIDTH + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [DATA_WIDTH-1:0] r_hold;
   logic [DATA_WIDTH-1:0] r_shift;
   logic                  r_hold_valid;
   logic                  r_par_bit;
   logic                  r_par_en;
   logic                  r_stop2;
   logic                  r_stop_rem;
   logic                  r_busy;
   logic [18:0]           r_cnt;
   logic [18:0]           r_per;
   logic [BW-1:0]         r_bit;
   logic [18:0]           w_per;
   logic                  w_accept;
   logic                  w_load;
   logic                  w_bit_end;
   logic                  w_last_stop;
   logic                  w_hold_nxt;
   logic                  w_txd;

   assign s_axis.tready = !r_hold_valid && !rst;
   assign w_accept      = s_axis.tvalid && s_axis.tready;
   assign w_bit_end     = (r_cnt == 19'd0);
   assign w_last_stop   = (r_state == S_STOP) && w_bit_end && !r_stop_rem;
   assign w_load        = r_hold_valid && ((r_state == S_IDLE) || w_last_stop);
   assign w_hold_nxt    = w_accept ? 1'b1 : (w_load ? 1'b0 : r_hold_valid);

   // Reload value for the bit counter; prescale 0 behaves as 1.
   assign w_per = (i_prescale == 16'd0) ? 19'd7 :
                  (({3'b000, i_prescale} << 3) - 19'd1);

   always_comb begin
      w_state_nxt = r_state;
      w_txd       = 1'b1;
      unique case (r_state)
         S_IDLE: begin
            if (w_load) w_state_nxt = S_START;
         end
         S_START: begin
            w_txd = 1'b0;
            if (w_bit_end) w_state_nxt = S_DATA;
         end
         S_DATA: begin
            w_txd = r_shift[0];
            if (w_bit_end && (r_bit == LAST_BIT))
               w_state_nxt = r_par_en ? S_PARITY : S_STOP;
         end
         S_PARITY: begin
            w_txd = r_par_bit;
            if (w_bit_end) w_state_nxt = S_STOP;
         end
         S_STOP: begin
            if (w_last_stop) w_state_nxt = w_load ? S_START : S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_hold_valid <= 1'b0;
         r_busy       <= 1'b0;
         r_cnt        <= '0;
         r_bit        <= '0;
         r_stop_rem   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_hold_valid <= w_hold_nxt;
         r_busy       <= (w_state_nxt != S_IDLE) || w_hold_nxt;
         if (w_load) begin
            r_cnt <= w_per;
            r_bit <= '0;
         end else if (r_state != S_IDLE) begin
            if (w_bit_end) begin
               r_cnt <= r_per;
               if (r_state == S_DATA) r_bit <= r_bit + BW'(1);
               if (r_state == S_STOP) r_stop_rem <= 1'b0;
               else if (w_state_nxt == S_STOP) r_stop_rem <= r_stop2;
            end else begin
               r_cnt <= r_cnt - 19'd1;
            end
         end
      end
   end

   // Frame settings are frozen at load so mid-frame changes are ignored.
   always_ff @(posedge clk) begin
      if (w_accept) r_hold <= s_axis.tdata;
      if (w_load) begin
         r_shift   <= r_hold;
         r_par_bit <= (^r_hold) ^ i_parity_odd;
         r_par_en  <= i_parity_en;
         r_stop2   <= i_stop2;
         r_per     <= w_per;
      end else if ((r_state == S_DATA) && w_bit_end) begin
         r_shift <= r_shift >> 1;
      end
   end

   assign o_txd  = w_txd;
   assign o_busy = r_busy;
endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter, the counterpart of `uart_rx`: accepts bytes on an AXI-Stream slave port and serialises them on `txd` as start / data (LSB first) / optional parity / stop. It uses the same bit timing as `uart_rx`, bit period = `prescale*8` clocks, so the two blocks loop back directly. A one-entry holding register lets the next byte be accepted during the current frame, so frames go out back-to-back.

## Interface
- `DATA_WIDTH`, 8, data bits per frame (5..9).
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `s_axis_tdata`  in  DATA_WIDTH  byte to send.
- `s_axis_tvalid`  in  1  `s_axis_tdata` valid.
- `s_axis_tready`  out  1  holding register empty. Equals `!hold_valid && !rst`.
- `txd`  out  1  serial line; idles high.
- `busy`  out  1  high while a frame is in progress or the holding register is full.
- `prescale`  in  16  bit period = `prescale*8` clocks; value 0 is treated as 1.
- `parity_en`  in  1  append a parity bit.
- `parity_odd`  in  1  select odd parity (else even); ignored when `parity_en`=0.
- `stop2`  in  1  send two stop bits (else one).

## Operation
- **Holding register**
  - A beat is accepted when `s_axis_tvalid && s_axis_tready`.
  - On acceptance the data is latched into `hold_data` and `hold_valid` is set.
- **Load**
  - A load occurs when `hold_valid`=1 and the FSM is in IDLE, or is in the last cycle of the last stop bit.
  - On a load, `hold_data` goes to the shift register and `hold_valid` clears.
  - `prescale`, `parity_en`, `parity_odd` and `stop2` are sampled into frame registers at the load. Changes during a frame have no effect.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE: `txd`=1.
  - IDLE -> START on load.
  - START -> DATA after 1 bit period.
  - DATA: sends DATA_WIDTH bits, LSB first, one bit period each. Then -> PARITY if `parity_en`, else -> STOP.
  - PARITY: sends one bit, the XOR of the data bits, inverted if `parity_odd`. Then -> STOP.
  - STOP: `txd`=1 for 1 bit period, or 2 if `stop2`. Then -> START if a load occurs, else -> IDLE.
- **Counters**
  - Bit-cycle counter is 19 bits wide (max 65535*8). It counts down from `prescale*8-1` to 0.
  - Bit index counter is `$clog2(DATA_WIDTH+1)` bits wide.
- `busy` = (state != IDLE) || `hold_valid`. It is registered, and reflects the state after each edge.
- **Reset, including mid-frame**, on the edge where `rst`=1:
  - state -> IDLE, `txd`=1, `hold_valid`=0, `busy`=0, counters cleared.
  - No partial frame resumes.
  - `s_axis_tready`=0 while `rst`=1.

## Timing
- Reset values: `txd`=1, `busy`=0, `s_axis_tready`=0 during reset and 1 in the first cycle after release.
- Latency:
  - Beat accepted at edge N: `hold_valid`=1 and `busy`=1 after N.
  - Load at edge N+1: `txd`=0 after N+1.
  - `s_axis_tready` returns to 1 after N+1.
- Every bit, including start, parity and stop, lasts exactly `prescale*8` clocks.
- Frame length: (1 + DATA_WIDTH + `parity_en` + 1 + `stop2`) bit periods.
- Back-to-back:
  - If `hold_valid`=1 at the last stop cycle, the next start bit begins on the following cycle, with zero idle gap.
  - `busy` stays high across the frame boundary.
- Empty holding register at the end of the stop bit(s): FSM -> IDLE, `busy` falls on the same edge that ends the stop bit.
- With `s_axis_tvalid` held high, at most 2 beats are buffered: one shifting, one held. The next beat is accepted the cycle after each load.

## Test plan
- **Single frame:** `prescale`=4, no parity, 1 stop, send 0xA5.
  - `txd` low 32 clocks, then bits 1,0,1,0,0,1,0,1 for 32 clocks each, then high 32 clocks: 320 clocks total.
  - `busy` high for 321 clocks from the acceptance edge.
  - Accept-to-`txd`-fall = 1 clock.
- **Back-to-back:** `s_axis_tvalid` held with 0xA5 then 0x3C.
  - Second beat accepted the cycle after the first load.
  - Start bit of 0x3C begins immediately after the 0xA5 stop bit; no idle cycle.
  - `busy` continuous.
- **Parity:** `parity_en`=1.
  - Even parity: 0x3C -> parity 0; 0x01 -> parity 1.
  - Odd parity: 0x3C -> parity 1.
  - Frame = 11 bit periods = 352 clocks at `prescale`=4.
- **Two stop bits and prescale latching:**
  - `stop2`=1: stop high for 64 clocks before the next start.
  - `prescale` changed 4 -> 8 mid-frame: current frame stays at 32 clocks/bit; the next frame uses 64.
  - `prescale`=0: 8 clocks/bit.
- **Loopback into `uart_rx`:** `prescale`=4 on both sides; send 0x00, 0xFF, 0x55, 0xA5, 0x3C back-to-back.
  - `uart_rx` outputs the same 5 bytes in order.
  - `frame_error`=0 and `overrun_error`=0 throughout.
- **Reset mid-frame:** assert `rst` for 1 cycle during data bit 3 of 0xA5, with a second byte held.
  - Next cycle: `txd`=1, `busy`=0, held byte discarded.
  - `s_axis_tready`=1 after release; a subsequent 0x3C transmits cleanly.
